// File: rtl/cve2_icache_lite_pkg.sv
// Shared types and widths for the lite instruction cache.
package cve2_icache_lite_pkg;

    localparam int unsigned IC_ADDR_W = 32;
    localparam int unsigned IC_DATA_W = 32;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_MISS = 1'b1
    } icache_state_e;

endpackage

// File: rtl/cve2_icache_lite_array.sv
// Flop-based valid/tag/data storage: async read, one write port, single-cycle flush.
module cve2_icache_lite_array
    import cve2_icache_lite_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_LINES),
    parameter int unsigned TAG_W     = IC_ADDR_W - IDX_W - 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic                 rd_valid_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [IC_DATA_W-1:0] rd_data_o,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic [IC_DATA_W-1:0] wr_data_i
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [IC_DATA_W-1:0] data_q [NUM_LINES];
    logic [IC_DATA_W-1:0] data_d [NUM_LINES];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    // Flush takes priority over a same-cycle fill for the valid bits.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (we_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
        if (we_i) begin
            tag_d[wr_idx_i]  = wr_tag_i;
            data_d[wr_idx_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data contents are qualified by valid and need no reset.
    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/cve2_icache_lite.sv
// Direct-mapped, word-granular instruction cache with a single outstanding miss.
module cve2_icache_lite
    import cve2_icache_lite_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 hit_o,
    output logic                 miss_o,
    input  logic                 instr_req_i,
    output logic                 instr_gnt_o,
    input  logic [IC_ADDR_W-1:0] instr_addr_i,
    output logic                 instr_rvalid_o,
    output logic [IC_DATA_W-1:0] instr_rdata_o,
    output logic                 instr_err_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [IC_ADDR_W-1:0] mem_addr_o,
    input  logic                 mem_rvalid_i,
    input  logic [IC_DATA_W-1:0] mem_rdata_i,
    input  logic                 mem_err_i
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = IC_ADDR_W - IDX_W - 2;

    icache_state_e        state_q, state_d;
    logic                 rvalid_q, rvalid_d;
    logic [IC_DATA_W-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]     miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
    logic                 flush_pending_q, flush_pending_d;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [IC_DATA_W-1:0] rd_data;
    logic                 lookup_hit;
    logic                 miss_rsp;
    logic                 fill_we;
    logic                 unused_addr;

    assign req_idx     = instr_addr_i[IDX_W+1:2];
    assign req_tag     = instr_addr_i[IC_ADDR_W-1:IDX_W+2];
    assign unused_addr = ^instr_addr_i[1:0];

    cve2_icache_lite_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_we),
        .wr_idx_i   (miss_idx_q),
        .wr_tag_i   (miss_tag_q),
        .wr_data_i  (mem_rdata_i)
    );

    assign lookup_hit = en_i & ~flush_i & rd_valid & (rd_tag == req_tag);
    assign miss_rsp   = (state_q == IC_MISS) & mem_rvalid_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IC_IDLE: if (instr_req_i && !lookup_hit && mem_gnt_i) state_d = IC_MISS;
            IC_MISS: if (mem_rvalid_i) state_d = IC_IDLE;
        endcase
    end

    // Request-path outputs and fill enable
    always_comb begin
        instr_gnt_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        hit_o       = 1'b0;
        miss_o      = 1'b0;
        fill_we     = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (instr_req_i) begin
                    if (lookup_hit) begin
                        instr_gnt_o = 1'b1;
                        hit_o       = 1'b1;
                    end else begin
                        mem_req_o   = 1'b1;
                        mem_addr_o  = {instr_addr_i[IC_ADDR_W-1:2], 2'b00};
                        instr_gnt_o = mem_gnt_i;
                        miss_o      = mem_gnt_i;
                    end
                end
            end
            IC_MISS: begin
                fill_we = mem_rvalid_i & en_i & ~mem_err_i & ~flush_pending_q & ~flush_i;
            end
        endcase
    end

    // Hit response pipeline, miss bookkeeping and deferred flush
    always_comb begin
        rvalid_d        = hit_o;
        rdata_d         = hit_o ? rd_data : rdata_q;
        miss_idx_d      = miss_o ? req_idx : miss_idx_q;
        miss_tag_d      = miss_o ? req_tag : miss_tag_q;
        flush_pending_d = 1'b0;
        if ((state_q == IC_MISS) && !mem_rvalid_i) begin
            flush_pending_d = flush_pending_q | flush_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q        <= 1'b0;
            rdata_q         <= '0;
            miss_idx_q      <= '0;
            miss_tag_q      <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            rvalid_q        <= rvalid_d;
            rdata_q         <= rdata_d;
            miss_idx_q      <= miss_idx_d;
            miss_tag_q      <= miss_tag_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Miss responses bypass the register so they return in the rvalid cycle.
    assign instr_rvalid_o = rvalid_q | miss_rsp;
    assign instr_rdata_o  = miss_rsp ? mem_rdata_i : rdata_q;
    assign instr_err_o    = miss_rsp & mem_err_i;
    assign busy_o         = (state_q == IC_MISS) | rvalid_q;

`ifndef SYNTHESIS
    mem_rvalid_in_idle_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((state_q == IC_IDLE) && mem_rvalid_i));
`endif

endmodule

// File: tb/tb_cve2_icache_lite.sv
// Directed, cycle-by-cycle vector bench for cve2_icache_lite.
module tb_cve2_icache_lite;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i, flush_i;
    logic        busy_o, hit_o, miss_o;
    logic        instr_req_i, instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        mem_req_o, mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    cve2_icache_lite #(.NUM_LINES(16)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .hit_o          (hit_o),
        .miss_o         (miss_o),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .mem_req_o      (mem_req_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_addr_o     (mem_addr_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        en;
        logic        fl;
        logic        mg;
        logic        mrv;
        logic [31:0] mrd;
        logic        merr;
        logic        gnt;
        logic        mreq;
        logic        hit;
        logic        miss;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic row(input int req, input logic [31:0] addr, input int en, input int fl,
                       input int mg, input int mrv, input logic [31:0] mrd, input int merr,
                       input int gnt, input int mreq, input int hit, input int miss,
                       input int rv, input logic [31:0] rdata, input int err, input int busy);
        vec_t v;
        v.req = 1'(req);   v.addr = addr;     v.en = 1'(en);     v.fl = 1'(fl);
        v.mg = 1'(mg);     v.mrv = 1'(mrv);   v.mrd = mrd;       v.merr = 1'(merr);
        v.gnt = 1'(gnt);   v.mreq = 1'(mreq); v.hit = 1'(hit);   v.miss = 1'(miss);
        v.rv = 1'(rv);     v.rdata = rdata;   v.err = 1'(err);   v.busy = 1'(busy);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic en, input logic fl,
                         input logic mg, input logic mrv, input logic [31:0] mrd, input logic merr);
        instr_req_i  = req;
        instr_addr_i = addr;
        en_i         = en;
        flush_i      = fl;
        mem_gnt_i    = mg;
        mem_rvalid_i = mrv;
        mem_rdata_i  = mrd;
        mem_err_i    = merr;
    endtask

    task automatic check_row(input int i, input vec_t v);
        logic [31:0] exp_maddr;
        exp_maddr = v.mreq ? {v.addr[31:2], 2'b00} : 32'h0;
        chk($sformatf("r%0d.gnt", i),    32'(instr_gnt_o),    32'(v.gnt));
        chk($sformatf("r%0d.mreq", i),   32'(mem_req_o),      32'(v.mreq));
        chk($sformatf("r%0d.maddr", i),  mem_addr_o,          exp_maddr);
        chk($sformatf("r%0d.hit", i),    32'(hit_o),          32'(v.hit));
        chk($sformatf("r%0d.miss", i),   32'(miss_o),         32'(v.miss));
        chk($sformatf("r%0d.rvalid", i), 32'(instr_rvalid_o), 32'(v.rv));
        chk($sformatf("r%0d.err", i),    32'(instr_err_o),    32'(v.err));
        chk($sformatf("r%0d.busy", i),   32'(busy_o),         32'(v.busy));
        if (v.rv) chk($sformatf("r%0d.rdata", i), instr_rdata_o, v.rdata);
    endtask

    initial begin
        logic got;
        rst_ni = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        //  req addr        en fl mg mrv mrdata      merr | gnt mreq hit miss rv rdata     err busy
        // cold fetch, then hit
        row(1, 32'h100, 1, 0, 0, 0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        0, 0);
        row(1, 32'h100, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 0, 32'h0,        0, 1);
        row(0, 32'h0,   1, 0, 0, 1, 32'hDEADBEEF, 0,   0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1);
        row(1, 32'h100, 1, 0, 0, 0, 32'h0,        0,   1, 0, 1, 0, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1);
        // conflict on index 0
        row(1, 32'h140, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'h11111111, 0,   0, 0, 0, 0, 1, 32'h11111111, 0, 1);
        row(1, 32'h100, 1, 0, 0, 0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        0, 0);
        row(1, 32'h100, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'hDEADBEEF, 0,   0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1);
        // errors are forwarded, never cached
        row(1, 32'h200, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'hBAD0BAD0, 1,   0, 0, 0, 0, 1, 32'hBAD0BAD0, 1, 1);
        row(1, 32'h200, 1, 0, 0, 0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        0, 0);
        row(1, 32'h200, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'h22222222, 1,   0, 0, 0, 0, 1, 32'h22222222, 1, 1);
        row(1, 32'h100, 1, 0, 0, 0, 32'h0,        0,   1, 0, 1, 0, 0, 32'h0,        0, 0);
        // flush with a lookup in the same cycle
        row(1, 32'h100, 1, 1, 0, 0, 32'h0,        0,   0, 1, 0, 0, 1, 32'hDEADBEEF, 0, 1);
        row(1, 32'h100, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'hDEADBEEF, 0,   0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1);
        // flush while a miss is outstanding suppresses its fill
        row(1, 32'h300, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 1, 0, 0, 32'h0,        0,   0, 0, 0, 0, 0, 32'h0,        0, 1);
        row(0, 32'h0,   1, 0, 0, 1, 32'h33333333, 0,   0, 0, 0, 0, 1, 32'h33333333, 0, 1);
        row(1, 32'h300, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'h33333333, 1,   0, 0, 0, 0, 1, 32'h33333333, 1, 1);
        // refill 0x100 / 0x104, then back-to-back hits and a stalled miss
        row(1, 32'h100, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'hDEADBEEF, 0,   0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1);
        row(1, 32'h104, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 1, 32'hCAFEF00D, 0,   0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 1);
        row(1, 32'h100, 1, 0, 0, 0, 32'h0,        0,   1, 0, 1, 0, 0, 32'h0,        0, 0);
        row(1, 32'h104, 1, 0, 0, 0, 32'h0,        0,   1, 0, 1, 0, 1, 32'hDEADBEEF, 0, 1);
        row(1, 32'h108, 1, 0, 0, 0, 32'h0,        0,   0, 1, 0, 0, 1, 32'hCAFEF00D, 0, 1);
        row(1, 32'h108, 1, 0, 0, 0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        0, 0);
        row(1, 32'h108, 1, 0, 0, 0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        0, 0);
        row(1, 32'h108, 1, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(1, 32'h108, 1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 0, 32'h0,        0, 1);
        row(1, 32'h100, 1, 0, 0, 1, 32'h44444444, 0,   0, 0, 0, 0, 1, 32'h44444444, 0, 1);
        row(1, 32'h100, 1, 0, 0, 0, 32'h0,        0,   1, 0, 1, 0, 0, 32'h0,        0, 0);
        row(1, 32'h108, 1, 0, 0, 0, 32'h0,        0,   1, 0, 1, 0, 1, 32'hDEADBEEF, 0, 1);
        row(0, 32'h0,   1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 1, 32'h44444444, 0, 1);
        // bypass mode keeps existing lines but never fills
        row(1, 32'h100, 0, 0, 0, 0, 32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        0, 0);
        row(1, 32'h100, 0, 0, 1, 0, 32'h0,        0,   1, 1, 0, 1, 0, 32'h0,        0, 0);
        row(0, 32'h0,   0, 0, 0, 1, 32'h55555555, 0,   0, 0, 0, 0, 1, 32'h55555555, 0, 1);
        row(1, 32'h100, 1, 0, 0, 0, 32'h0,        0,   1, 0, 1, 0, 0, 32'h0,        0, 0);
        row(0, 32'h0,   1, 0, 0, 0, 32'h0,        0,   0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 1);

        // reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst.busy",   32'(busy_o),         32'h0);
        chk("rst.rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("rst.mreq",   32'(mem_req_o),      32'h0);
        rst_ni = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk_i); #1;
            drive(vecs[i].req, vecs[i].addr, vecs[i].en, vecs[i].fl,
                  vecs[i].mg, vecs[i].mrv, vecs[i].mrd, vecs[i].merr);
            @(negedge clk_i);
            check_row(i, vecs[i]);
        end

        // reset in the middle of a miss drops it and clears every line
        @(posedge clk_i); #1;
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        chk("mid.miss", 32'(miss_o), 32'h1);
        @(posedge clk_i); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        chk("mid.busy", 32'(busy_o), 32'h1);
        #1 rst_ni = 1'b0;
        #1 chk("mid.rst_busy", 32'(busy_o), 32'h0);
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // 0x100 must miss after reset; grant arrives after a few stalled cycles
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            drive(1'b1, 32'h100, 1'b1, 1'b0, 1'(i == 2), 1'b0, 32'h0, 1'b0);
            @(negedge clk_i);
            chk($sformatf("post.hit%0d", i), 32'(hit_o), 32'h0);
            if (instr_gnt_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("post.gnt_wait", 32'(got), 32'h1);
        @(posedge clk_i); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk_i); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h66666666, 1'b0);
        @(negedge clk_i);
        chk("post.rvalid", 32'(instr_rvalid_o), 32'h1);
        chk("post.rdata",  instr_rdata_o,       32'h66666666);
        @(posedge clk_i); #1;
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        chk("post.rehit", 32'(hit_o), 32'h1);
        @(posedge clk_i); #1;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        chk("post.hit_rvalid", 32'(instr_rvalid_o), 32'h1);
        chk("post.hit_rdata",  instr_rdata_o,       32'h66666666);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
